player_sprite_ctrl: RTL and testbench

//  Next-generation player-plane controller: position, lives, explode/respawn/invincibility FSM, sprite pixel pipe.

---
 rtl/player_pkg.sv | 21 ++
 rtl/player_sprite_ctrl_pixel_pipe.sv | 63 ++++++
 rtl/player_sprite_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_player_sprite_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/player_pkg.sv
// Shared types and constants for the player sprite controller.
//   state_t  : player life-cycle state
//   DIR_*    : bit index of each key within the 4-bit direction bus
//   RGB_W    : pixel colour width
package player_pkg;

  typedef enum logic [1:0] {
    ALIVE      = 2'd0,
    EXPLODING  = 2'd1,
    INVINCIBLE = 2'd2,
    DEAD       = 2'd3
  } state_t;

  localparam int DIR_UP    = 0;
  localparam int DIR_DOWN  = 1;
  localparam int DIR_LEFT  = 2;
  localparam int DIR_RIGHT = 3;

  localparam int RGB_W = 12;

endpackage

// File: rtl/player_sprite_ctrl_pixel_pipe.sv
// sprite_pixel_pipe: in-box test, sprite ROM address and the two-stage
// pixel output registers.
// Ports:
//   clk, rst        clock, async active-high reset
//   x, y            current scan pixel
//   p_x, p_y        sprite top-left corner
//   draw_ok         layer may draw this cycle (state-dependent gate)
//   rom_data        ROM word for the address presented one cycle earlier
//   rom_addr        combinational ROM address (don't-care outside the box)
//   pix_en, rgb     registered pixel enable and colour, 2 clk after x/y
module sprite_pixel_pipe
  import player_pkg::*;
#(
  parameter int                COORD_W = 10,
  parameter int                SPR_W   = 50,
  parameter int                SPR_H   = 50,
  parameter int                ADDR_W  = 12,
  parameter logic [RGB_W-1:0]  KEY_RGB = 12'hFFF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [COORD_W-1:0] p_x,
  input  logic [COORD_W-1:0] p_y,
  input  logic               draw_ok,
  input  logic [RGB_W-1:0]   rom_data,
  output logic [ADDR_W-1:0]  rom_addr,
  output logic               pix_en,
  output logic [RGB_W-1:0]   rgb
);

  logic [COORD_W:0]  x_w, y_w, px_w, py_w;
  logic              in_box, in_box_d;
  logic [ADDR_W-1:0] dx_a, dy_a;

  // One extra bit so p_x+SPR_W cannot overflow near the right/bottom edge.
  assign x_w  = {1'b0, x};
  assign y_w  = {1'b0, y};
  assign px_w = {1'b0, p_x};
  assign py_w = {1'b0, p_y};

  assign in_box = (x_w >= px_w) && (x_w < px_w + (COORD_W+1)'(SPR_W)) &&
                  (y_w >= py_w) && (y_w < py_w + (COORD_W+1)'(SPR_H));

  // Modular arithmetic is exact inside the box; outside it nobody looks.
  assign dx_a     = ADDR_W'(x - p_x);
  assign dy_a     = ADDR_W'(y - p_y);
  assign rom_addr = dy_a * ADDR_W'(SPR_W) + dx_a;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_box_d <= 1'b0;
      pix_en   <= 1'b0;
      rgb      <= '0;
    end else begin
      in_box_d <= in_box;
      rgb      <= rom_data;
      pix_en   <= in_box_d && (rom_data != KEY_RGB) && draw_ok;
    end
  end

endmodule

// File: rtl/player_sprite_ctrl.sv
// player_sprite_ctrl: player plane position, lives and explode/respawn FSM,
// driving one sprite layer of the VGA compositor.
// Optional feature macro: PLAYER_SPRITE_BLINK_EN (sprite blinks while
// invincible; when undefined the sprite draws solid).
// Ports:
//   clk, rst        clock, async active-high reset
//   move_tick       1-cycle movement strobe
//   x, y            current scan pixel
//   direction       [0]up [1]down [2]left [3]right
//   hit             collision pulse
//   rom_addr        sprite/explosion ROM address (combinational)
//   rom_sel         0 plane ROM, 1 explosion ROM
//   rom_data        ROM word, 1 cycle after rom_addr
//   p_x, p_y        sprite top-left corner
//   lives           remaining lives
//   alive           ALIVE or INVINCIBLE
//   game_over       DEAD
//   pix_en, rgb     registered pixel enable / colour
//
// state      | meaning
// ALIVE      | normal play, moves, hit starts explosion
// EXPLODING  | explosion sprite, frozen, hit ignored
// INVINCIBLE | respawned, moves, hit ignored
// DEAD       | no lives left, terminal until rst
module player_sprite_ctrl
  import player_pkg::*;
#(
  parameter int               COORD_W    = 10,
  parameter int               SCR_W      = 640,
  parameter int               SCR_H      = 480,
  parameter int               SPR_W      = 50,
  parameter int               SPR_H      = 50,
  parameter int               SPEED      = 1,
  parameter int               LIVES      = 3,
  parameter int               BOOM_TICKS = 64,
  parameter int               INV_TICKS  = 128,
  parameter logic [RGB_W-1:0] KEY_RGB    = 12'hFFF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           move_tick,
  input  logic [COORD_W-1:0]             x,
  input  logic [COORD_W-1:0]             y,
  input  logic [3:0]                     direction,
  input  logic                           hit,
  output logic [$clog2(SPR_W*SPR_H)-1:0] rom_addr,
  output logic                           rom_sel,
  input  logic [RGB_W-1:0]               rom_data,
  output logic [COORD_W-1:0]             p_x,
  output logic [COORD_W-1:0]             p_y,
  output logic [$clog2(LIVES+1)-1:0]     lives,
  output logic                           alive,
  output logic                           game_over,
  output logic                           pix_en,
  output logic [RGB_W-1:0]               rgb
);

  localparam int ADDR_W  = $clog2(SPR_W*SPR_H);
  localparam int LIVES_W = $clog2(LIVES+1);
  localparam int CNT_W   = $clog2((BOOM_TICKS > INV_TICKS) ? BOOM_TICKS : INV_TICKS);
  localparam int SW      = COORD_W + 2;

  localparam logic [COORD_W-1:0]   SPAWN_X   = COORD_W'((SCR_W - SPR_W) / 2);
  localparam logic [COORD_W-1:0]   SPAWN_Y   = COORD_W'(SCR_H - SPR_H);
  localparam logic signed [SW-1:0] X_MAX     = SW'(SCR_W - SPR_W);
  localparam logic signed [SW-1:0] Y_MAX     = SW'(SCR_H - SPR_H);
  localparam logic signed [SW-1:0] SPD       = SW'(SPEED);
  localparam logic [CNT_W-1:0]     BOOM_LAST = CNT_W'(BOOM_TICKS - 1);
  localparam logic [CNT_W-1:0]     INV_LAST  = CNT_W'(INV_TICKS - 1);

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [LIVES_W-1:0]   lives_nxt;
  logic [COORD_W-1:0]   px_nxt, py_nxt, px_mv, py_mv;
  logic signed [SW-1:0] step_x, step_y, nx, ny;
  logic                 draw_ok;

  // Candidate moved position; opposite keys on one axis cancel.
  always_comb begin
    step_x = '0;
    step_y = '0;
    if (direction[DIR_RIGHT] && !direction[DIR_LEFT]) step_x = SPD;
    else if (direction[DIR_LEFT] && !direction[DIR_RIGHT]) step_x = -SPD;
    if (direction[DIR_DOWN] && !direction[DIR_UP]) step_y = SPD;
    else if (direction[DIR_UP] && !direction[DIR_DOWN]) step_y = -SPD;
    nx = $signed({2'b00, p_x}) + step_x;
    ny = $signed({2'b00, p_y}) + step_y;
    if (nx < 0)          px_mv = '0;
    else if (nx > X_MAX) px_mv = X_MAX[COORD_W-1:0];
    else                 px_mv = nx[COORD_W-1:0];
    if (ny < 0)          py_mv = '0;
    else if (ny > Y_MAX) py_mv = Y_MAX[COORD_W-1:0];
    else                 py_mv = ny[COORD_W-1:0];
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    lives_nxt = lives;
    px_nxt    = p_x;
    py_nxt    = p_y;
    case (state)
      ALIVE: begin
        // hit takes priority over a same-cycle move
        if (hit) begin
          state_nxt = EXPLODING;
          cnt_nxt   = '0;
          if (lives != '0) lives_nxt = lives - 1'b1;
        end else if (move_tick) begin
          px_nxt = px_mv;
          py_nxt = py_mv;
        end
      end
      EXPLODING: begin
        if (move_tick) begin
          if (cnt == BOOM_LAST) begin
            if (lives != '0) begin
              state_nxt = INVINCIBLE;
              cnt_nxt   = '0;
              px_nxt    = SPAWN_X;
              py_nxt    = SPAWN_Y;
            end else begin
              state_nxt = DEAD;
            end
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      INVINCIBLE: begin
        if (move_tick) begin
          px_nxt = px_mv;
          py_nxt = py_mv;
          if (cnt == INV_LAST) begin
            state_nxt = ALIVE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ALIVE;
      cnt   <= '0;
      lives <= LIVES_W'(LIVES);
      p_x   <= SPAWN_X;
      p_y   <= SPAWN_Y;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      lives <= lives_nxt;
      p_x   <= px_nxt;
      p_y   <= py_nxt;
    end
  end

  assign rom_sel   = (state == EXPLODING);
  assign alive     = (state == ALIVE) || (state == INVINCIBLE);
  assign game_over = (state == DEAD);

`ifdef PLAYER_SPRITE_BLINK_EN
  // Hidden for 8 ticks out of every 16 while invincible.
  assign draw_ok = (state != DEAD) && !((state == INVINCIBLE) && cnt[3]);
`else
  assign draw_ok = (state != DEAD);
`endif

  sprite_pixel_pipe #(
    .COORD_W (COORD_W),
    .SPR_W   (SPR_W),
    .SPR_H   (SPR_H),
    .ADDR_W  (ADDR_W),
    .KEY_RGB (KEY_RGB)
  ) u_pipe (
    .clk      (clk),
    .rst      (rst),
    .x        (x),
    .y        (y),
    .p_x      (p_x),
    .p_y      (p_y),
    .draw_ok  (draw_ok),
    .rom_data (rom_data),
    .rom_addr (rom_addr),
    .pix_en   (pix_en),
    .rgb      (rgb)
  );

endmodule

// File: tb/tb_player_sprite_ctrl.sv
module tb_player_sprite_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        move_tick = 1'b0;
  logic [9:0]  x = '0, y = '0;
  logic [3:0]  direction = '0;
  logic        hit = 1'b0;
  logic [11:0] rom_addr;
  logic        rom_sel;
  logic [11:0] rom_data = '0;
  logic [9:0]  p_x, p_y;
  logic [1:0]  lives;
  logic        alive, game_over, pix_en;
  logic [11:0] rgb;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  player_sprite_ctrl dut (
    .clk(clk), .rst(rst), .move_tick(move_tick), .x(x), .y(y),
    .direction(direction), .hit(hit), .rom_addr(rom_addr), .rom_sel(rom_sel),
    .rom_data(rom_data), .p_x(p_x), .p_y(p_y), .lives(lives), .alive(alive),
    .game_over(game_over), .pix_en(pix_en), .rgb(rgb)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n, input logic [3:0] d);
    direction = d;
    move_tick = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    move_tick = 1'b0;
    direction = '0;
  endtask

  task automatic pulse_hit();
    hit = 1'b1;
    @(posedge clk);
    #1;
    hit = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; move_tick = 1'b0; hit = 1'b0; direction = '0;
    x = '0; y = '0; rom_data = '0;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (p_x !== 10'd295) begin n_fail++; $display("FAIL reset_px got %0d want 295", p_x); end
    n_checks++; if (p_y !== 10'd430) begin n_fail++; $display("FAIL reset_py got %0d want 430", p_y); end
    n_checks++; if (lives !== 2'd3) begin n_fail++; $display("FAIL reset_lives got %0d want 3", lives); end
    n_checks++; if (alive !== 1'b1) begin n_fail++; $display("FAIL reset_alive got %b want 1", alive); end
    n_checks++; if (game_over !== 1'b0) begin n_fail++; $display("FAIL reset_game_over got %b want 0", game_over); end
    n_checks++; if (rom_sel !== 1'b0) begin n_fail++; $display("FAIL reset_rom_sel got %b want 0", rom_sel); end
    n_checks++; if (pix_en !== 1'b0) begin n_fail++; $display("FAIL reset_pix_en got %b want 0", pix_en); end
    n_checks++; if (rgb !== 12'h000) begin n_fail++; $display("FAIL reset_rgb got %h want 000", rgb); end
  endtask

  task automatic test_move();
    do_reset();
    ticks(10, 4'b1000);
    n_checks++; if (p_x !== 10'd305) begin n_fail++; $display("FAIL move_right_px got %0d want 305", p_x); end
    n_checks++; if (p_y !== 10'd430) begin n_fail++; $display("FAIL move_right_py got %0d want 430", p_y); end
    ticks(3, 4'b0100);
    n_checks++; if (p_x !== 10'd302) begin n_fail++; $display("FAIL move_left_px got %0d want 302", p_x); end
    ticks(5, 4'b1001);
    n_checks++; if (p_x !== 10'd307) begin n_fail++; $display("FAIL diag_px got %0d want 307", p_x); end
    n_checks++; if (p_y !== 10'd425) begin n_fail++; $display("FAIL diag_py got %0d want 425", p_y); end
    ticks(10, 4'b1111);
    n_checks++; if (p_x !== 10'd307 || p_y !== 10'd425) begin n_fail++; $display("FAIL cancel_all got %0d,%0d want 307,425", p_x, p_y); end
  endtask

  task automatic test_clamp();
    do_reset();
    ticks(500, 4'b0101);
    n_checks++; if (p_x !== 10'd0) begin n_fail++; $display("FAIL clamp_left_px got %0d want 0", p_x); end
    n_checks++; if (p_y !== 10'd0) begin n_fail++; $display("FAIL clamp_up_py got %0d want 0", p_y); end
    ticks(10, 4'b0011);
    n_checks++; if (p_x !== 10'd0 || p_y !== 10'd0) begin n_fail++; $display("FAIL cancel_ud got %0d,%0d want 0,0", p_x, p_y); end
    ticks(700, 4'b1010);
    n_checks++; if (p_x !== 10'd590) begin n_fail++; $display("FAIL clamp_right_px got %0d want 590", p_x); end
    n_checks++; if (p_y !== 10'd430) begin n_fail++; $display("FAIL clamp_down_py got %0d want 430", p_y); end
  endtask

  task automatic test_hit();
    do_reset();
    ticks(5, 4'b1000);
    pulse_hit();
    n_checks++; if (lives !== 2'd2) begin n_fail++; $display("FAIL hit_lives got %0d want 2", lives); end
    n_checks++; if (rom_sel !== 1'b1) begin n_fail++; $display("FAIL hit_rom_sel got %b want 1", rom_sel); end
    n_checks++; if (alive !== 1'b0) begin n_fail++; $display("FAIL hit_alive got %b want 0", alive); end
    pulse_hit();
    n_checks++; if (lives !== 2'd2) begin n_fail++; $display("FAIL explode_hit_ignored got %0d want 2", lives); end
    ticks(63, 4'b1000);
    n_checks++; if (rom_sel !== 1'b1) begin n_fail++; $display("FAIL boom_63_rom_sel got %b want 1", rom_sel); end
    n_checks++; if (p_x !== 10'd300) begin n_fail++; $display("FAIL boom_frozen_px got %0d want 300", p_x); end
    ticks(1, 4'b1000);
    n_checks++; if (rom_sel !== 1'b0 || alive !== 1'b1) begin n_fail++; $display("FAIL respawn_state got rom_sel=%b alive=%b want 0,1", rom_sel, alive); end
    n_checks++; if (p_x !== 10'd295 || p_y !== 10'd430) begin n_fail++; $display("FAIL respawn_pos got %0d,%0d want 295,430", p_x, p_y); end
    pulse_hit();
    n_checks++; if (lives !== 2'd2 || rom_sel !== 1'b0) begin n_fail++; $display("FAIL inv_hit_ignored got lives=%0d rom_sel=%b want 2,0", lives, rom_sel); end
    ticks(127, 4'b0000);
    pulse_hit();
    n_checks++; if (lives !== 2'd2) begin n_fail++; $display("FAIL inv_127_hit_ignored got %0d want 2", lives); end
    ticks(1, 4'b0000);
    pulse_hit();
    n_checks++; if (lives !== 2'd1 || rom_sel !== 1'b1) begin n_fail++; $display("FAIL alive_again_hit got lives=%0d rom_sel=%b want 1,1", lives, rom_sel); end
  endtask

  task automatic test_game_over();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      pulse_hit();
      ticks(64, 4'b0000);
      if (i < 2) ticks(128, 4'b0000);
    end
    n_checks++; if (game_over !== 1'b1) begin n_fail++; $display("FAIL go_game_over got %b want 1", game_over); end
    n_checks++; if (lives !== 2'd0) begin n_fail++; $display("FAIL go_lives got %0d want 0", lives); end
    n_checks++; if (alive !== 1'b0 || rom_sel !== 1'b0) begin n_fail++; $display("FAIL go_flags got alive=%b rom_sel=%b want 0,0", alive, rom_sel); end
    x = 10'd300; y = 10'd440; rom_data = 12'h0F0;
    step(3);
    n_checks++; if (pix_en !== 1'b0) begin n_fail++; $display("FAIL go_pix_en got %b want 0", pix_en); end
    pulse_hit();
    ticks(5, 4'b1000);
    n_checks++; if (game_over !== 1'b1 || lives !== 2'd0 || p_x !== 10'd295) begin n_fail++; $display("FAIL go_terminal got go=%b lives=%0d px=%0d want 1,0,295", game_over, lives, p_x); end
  endtask

  task automatic test_pixel();
    do_reset();
    rom_data = 12'h0F0; x = 10'd0; y = 10'd0;
    step(2);
    n_checks++; if (pix_en !== 1'b0) begin n_fail++; $display("FAIL pix_outside got %b want 0", pix_en); end
    x = 10'd300; y = 10'd440;
    #1;
    n_checks++; if (rom_addr !== 12'd505) begin n_fail++; $display("FAIL pix_addr got %0d want 505", rom_addr); end
    step(1);
    n_checks++; if (pix_en !== 1'b0) begin n_fail++; $display("FAIL pix_lat1 got %b want 0", pix_en); end
    step(1);
    n_checks++; if (pix_en !== 1'b1 || rgb !== 12'h0F0) begin n_fail++; $display("FAIL pix_lat2 got en=%b rgb=%h want 1,0F0", pix_en, rgb); end
    rom_data = 12'hFFF;
    step(1);
    n_checks++; if (pix_en !== 1'b0 || rgb !== 12'hFFF) begin n_fail++; $display("FAIL pix_key got en=%b rgb=%h want 0,FFF", pix_en, rgb); end
    rom_data = 12'h0F0; x = 10'd345;
    step(2);
    n_checks++; if (pix_en !== 1'b0) begin n_fail++; $display("FAIL pix_right_edge got %b want 0", pix_en); end
    x = 10'd295; y = 10'd430;
    #1;
    n_checks++; if (rom_addr !== 12'd0) begin n_fail++; $display("FAIL pix_corner_addr got %0d want 0", rom_addr); end
    step(2);
    n_checks++; if (pix_en !== 1'b1) begin n_fail++; $display("FAIL pix_corner got %b want 1", pix_en); end
    x = 10'd294;
    step(2);
    n_checks++; if (pix_en !== 1'b0) begin n_fail++; $display("FAIL pix_left_edge got %b want 0", pix_en); end
    x = 10'd300; y = 10'd429;
    step(2);
    n_checks++; if (pix_en !== 1'b0) begin n_fail++; $display("FAIL pix_top_edge got %b want 0", pix_en); end
  endtask

  task automatic test_hit_tick();
    do_reset();
    ticks(5, 4'b1000);
    direction = 4'b1000; hit = 1'b1; move_tick = 1'b1;
    step(1);
    hit = 1'b0; move_tick = 1'b0; direction = '0;
    n_checks++; if (p_x !== 10'd300) begin n_fail++; $display("FAIL hit_tick_px got %0d want 300", p_x); end
    n_checks++; if (rom_sel !== 1'b1 || lives !== 2'd2) begin n_fail++; $display("FAIL hit_tick_state got rom_sel=%b lives=%0d want 1,2", rom_sel, lives); end
    ticks(10, 4'b0000);
    x = 10'd300; y = 10'd440; rom_data = 12'h0F0;
    step(2);
    n_checks++; if (pix_en !== 1'b1) begin n_fail++; $display("FAIL explode_draw got %b want 1", pix_en); end
    rst = 1'b1;
    #1;
    n_checks++; if (p_x !== 10'd295 || p_y !== 10'd430 || lives !== 2'd3) begin n_fail++; $display("FAIL rst_mid_pos got %0d,%0d lives=%0d want 295,430,3", p_x, p_y, lives); end
    n_checks++; if (rom_sel !== 1'b0 || alive !== 1'b1 || game_over !== 1'b0) begin n_fail++; $display("FAIL rst_mid_flags got sel=%b alive=%b go=%b want 0,1,0", rom_sel, alive, game_over); end
    n_checks++; if (pix_en !== 1'b0 || rgb !== 12'h000) begin n_fail++; $display("FAIL rst_mid_pix got en=%b rgb=%h want 0,000", pix_en, rgb); end
    step(1);
    rst = 1'b0;
    step(1);
  endtask

  initial begin
    test_reset();
    test_move();
    test_clamp();
    test_hit();
    test_game_over();
    test_pixel();
    test_hit_tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
